ph_transmitter: RTL and testbench

- Host-side USB packet transmitter; the transmit-direction counterpart of the packet receive path.
- Accepts one packet request from the read/write FSM and builds the packet: SYNC, PID, token fields or 64-bit DATA0 payload, CRC5/CRC16.
- Bit-stuffs and NRZI-encodes the bit stream, then drives it onto DP/DM one bit per clock, finishing with EOP.
- Asserts host_sending for the whole packet so the receive path ignores the bus while the host drives it.

---
 rtl/usb_pkg.sv | 48 ++++
 rtl/usb_crc_gen.sv | 45 ++++
 rtl/ph_transmitter.sv | 185 ++++++++++++++++++
 tb/tb_ph_transmitter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions for the host packet path: packet kinds, PID bytes,
// SYNC pattern, CRC parameters and line-state encodings.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_OUT   = 3'd0,
    PKT_IN    = 3'd1,
    PKT_ACK   = 3'd2,
    PKT_NAK   = 3'd3,
    PKT_DATA0 = 3'd4
  } pkt_t;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  // Bit 0 goes out first: seven 0s then a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam int          CRC5_WIDTH  = 5;
  localparam int          CRC16_WIDTH = 16;
  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_SEED   = 5'h1F;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_SEED  = 16'hFFFF;

  // {DP, DM}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [7:0] pid_of(input pkt_t kind);
    case (kind)
      PKT_OUT:   pid_of = PID_OUT;
      PKT_IN:    pid_of = PID_IN;
      PKT_NAK:   pid_of = PID_NAK;
      PKT_DATA0: pid_of = PID_DATA0;
      default:   pid_of = PID_ACK;
    endcase
  endfunction

  function automatic logic pkt_legal(input logic [2:0] kind);
    pkt_legal = (kind <= 3'd4);
  endfunction

endpackage

// File: rtl/usb_crc_gen.sv
// Serial USB CRC generator (CRC5 or CRC16); shifts out the complemented
// remainder MSB first once the covered field has been fed in.
module usb_crc_gen
  import usb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic mode_16,
  input  logic shift_en,
  input  logic bit_in,
  input  logic shift_out,
  output logic crc_bit
);

  logic [15:0] crc_q;
  logic        mode_q;
  logic        msb;
  logic        fb;
  logic [15:0] poly;

  always_comb begin
    msb  = mode_q ? crc_q[CRC16_WIDTH-1] : crc_q[CRC5_WIDTH-1];
    fb   = bit_in ^ msb;
    poly = mode_q ? CRC16_POLY : {{(16-CRC5_WIDTH){1'b0}}, CRC5_POLY};
  end

  assign crc_bit = ~msb;

  // In CRC5 mode the upper bits collect junk that is never observed.
  always_ff @(posedge clock) begin
    if (reset) begin
      crc_q  <= CRC16_SEED;
      mode_q <= 1'b0;
    end else if (clear) begin
      mode_q <= mode_16;
      crc_q  <= mode_16 ? CRC16_SEED : {{(16-CRC5_WIDTH){1'b0}}, CRC5_SEED};
    end else if (shift_en) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end else if (shift_out) begin
      crc_q <= {crc_q[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/ph_transmitter.sv
// Host-side USB packet transmitter: builds SYNC/PID/token or DATA0/CRC,
// bit-stuffs, NRZI-encodes and drives DP/DM one bit per clock, then EOP.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | line at J, waiting for a legal start
// S_SYNC    | 8 SYNC bits
// S_PID     | 8 PID bits, LSB first
// S_TOKEN   | 7 addr + 4 endp bits, LSB first
// S_DATA    | DATA_BITS payload bits, bit 0 first
// S_CRC     | complemented CRC5/CRC16, MSB first
// S_EOP_SE0 | owed stuff bit (if any), then 2 cycles of SE0
// S_EOP_J   | 1 cycle of J, then done
module ph_transmitter
  import usb_pkg::*;
#(
  parameter int DATA_BITS   = 64,
  parameter int STUFF_LIMIT = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  pkt_t                 pkt_type,
  input  logic [6:0]           addr,
  input  logic [3:0]           endp,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 DP_out,
  output logic                 DM_out,
  output logic                 host_sending,
  output logic                 ready,
  output logic                 done
);

  localparam int DIDX_W = $clog2(DATA_BITS);
  localparam int IDX_W  = (DIDX_W > 4) ? DIDX_W : 4;
  localparam int CNT_W  = $clog2(STUFF_LIMIT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PID     = 3'd2;
  localparam logic [2:0] S_TOKEN   = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_CRC     = 3'd5;
  localparam logic [2:0] S_EOP_SE0 = 3'd6;
  localparam logic [2:0] S_EOP_J   = 3'd7;

  logic [2:0]           state;
  logic [2:0]           next_field;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     field_last;
  logic [CNT_W-1:0]     stuff_cnt;
  logic                 line_prev;
  pkt_t                 pkt_q;
  logic [10:0]          token_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic [7:0]           pid_byte;
  logic [1:0]           line;
  logic accept, in_field, stuff_now, field_end;
  logic raw_bit, wire_bit, level, crc_bit;

  assign pid_byte = pid_of(pkt_q);

  always_comb begin
    raw_bit    = 1'b0;
    field_last = '0;
    next_field = S_EOP_SE0;
    case (state)
      S_SYNC: begin
        raw_bit    = SYNC_PATTERN[bit_idx[2:0]];
        field_last = IDX_W'(7);
        next_field = S_PID;
      end
      S_PID: begin
        raw_bit    = pid_byte[bit_idx[2:0]];
        field_last = IDX_W'(7);
        if (pkt_q == PKT_DATA0)
          next_field = S_DATA;
        else if (pkt_q == PKT_OUT || pkt_q == PKT_IN)
          next_field = S_TOKEN;
      end
      S_TOKEN: begin
        raw_bit    = token_q[bit_idx[3:0]];
        field_last = IDX_W'(10);
        next_field = S_CRC;
      end
      S_DATA: begin
        raw_bit    = data_q[bit_idx[DIDX_W-1:0]];
        field_last = IDX_W'(DATA_BITS - 1);
        next_field = S_CRC;
      end
      S_CRC: begin
        raw_bit    = crc_bit;
        field_last = (pkt_q == PKT_DATA0) ? IDX_W'(CRC16_WIDTH - 1) : IDX_W'(CRC5_WIDTH - 1);
      end
      default: ;
    endcase
  end

  assign accept    = start && (state == S_IDLE) && pkt_legal(pkt_type);
  assign in_field  = (state inside {S_SYNC, S_PID, S_TOKEN, S_DATA, S_CRC});
  // EOP_SE0 is included so a stuff owed by the last CRC bit goes out first.
  assign stuff_now = (in_field || state == S_EOP_SE0) && (stuff_cnt == CNT_W'(STUFF_LIMIT));
  assign field_end = (bit_idx == field_last);
  assign wire_bit  = stuff_now ? 1'b0 : raw_bit;
  assign level     = wire_bit ? line_prev : ~line_prev;

  always_comb begin
    line = LINE_J;
    if (in_field || stuff_now)
      line = level ? LINE_J : LINE_K;
    else if (state == S_EOP_SE0)
      line = LINE_SE0;
  end

  assign {DP_out, DM_out} = line;
  assign host_sending     = (state != S_IDLE);
  assign ready            = (state == S_IDLE);
  assign done             = done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      stuff_cnt <= '0;
      line_prev <= 1'b1;
      pkt_q     <= PKT_ACK;
      token_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_field || stuff_now)
        line_prev <= level;
      if (stuff_now) begin
        stuff_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            pkt_q     <= pkt_type;
            token_q   <= {endp, addr};
            data_q    <= data_in;
            state     <= S_SYNC;
            bit_idx   <= '0;
            stuff_cnt <= '0;
            line_prev <= 1'b1;
          end
          S_EOP_SE0: begin
            if (bit_idx == IDX_W'(1)) begin
              state   <= S_EOP_J;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          S_EOP_J: begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
          default: begin
            stuff_cnt <= raw_bit ? stuff_cnt + 1'b1 : '0;
            if (field_end) begin
              state   <= next_field;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        endcase
      end
    end
  end

  usb_crc_gen u_crc (
    .clock     (clock),
    .reset     (reset),
    .clear     (accept),
    .mode_16   (pkt_type == PKT_DATA0),
    .shift_en  ((state == S_TOKEN || state == S_DATA) && !stuff_now),
    .bit_in    (raw_bit),
    .shift_out ((state == S_CRC) && !stuff_now),
    .crc_bit   (crc_bit)
  );

endmodule

// File: tb/tb_ph_transmitter.sv
// Directed bench for ph_transmitter: captures DP/DM, decodes NRZI and
// stuffing, and checks packets against hand values and a CRC reference.
module tb_ph_transmitter;
  import usb_pkg::*;

  localparam int STUFF = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  pkt_t        pkt_type;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data_in;
  logic        DP_out, DM_out, host_sending, ready, done;

  ph_transmitter #(.DATA_BITS(64), .STUFF_LIMIT(6)) dut (
    .clock(clock), .reset(reset), .start(start), .pkt_type(pkt_type),
    .addr(addr), .endp(endp), .data_in(data_in), .DP_out(DP_out),
    .DM_out(DM_out), .host_sending(host_sending), .ready(ready), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]   line_buf [0:511];
  int           n_lines;
  logic [127:0] got_raw, exp_raw;
  int           n_raw, n_exp, n_stuff, exp_stuff, stuff_pre, crc_start;
  int           bad_stuff, n_se0, eop_j;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_pid(input pkt_t t);
    case (t)
      PKT_OUT:   return 8'hE1;
      PKT_IN:    return 8'h69;
      PKT_DATA0: return 8'hC3;
      PKT_NAK:   return 8'h5A;
      default:   return 8'hD2;
    endcase
  endfunction

  // Reference serial CRC, returns complemented remainder.
  function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n, input int w);
    logic [15:0] c, poly, mask;
    logic fb;
    mask = (w == 16) ? 16'hFFFF : 16'h001F;
    poly = (w == 16) ? 16'h8005 : 16'h0005;
    c = mask;
    for (int i = 0; i < n; i++) begin
      fb = bits[i] ^ c[w-1];
      c = (c << 1) & mask;
      if (fb) c = c ^ poly;
    end
    return ~c & mask;
  endfunction

  task automatic push(input logic [63:0] v, input int n, input bit msb_first);
    for (int i = 0; i < n; i++) begin
      exp_raw[n_exp] = msb_first ? v[n-1-i] : v[i];
      n_exp++;
    end
  endtask

  task automatic build_exp(input pkt_t t, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d);
    int ones;
    exp_raw = '0;
    n_exp = 0;
    push(64'h80, 8, 1'b0);
    push({56'h0, tb_pid(t)}, 8, 1'b0);
    crc_start = 16;
    if (t == PKT_OUT || t == PKT_IN) begin
      push({53'h0, e, a}, 11, 1'b0);
      crc_start = n_exp;
      push({48'h0, crc_ref({53'h0, e, a}, 11, 5)}, 5, 1'b1);
    end else if (t == PKT_DATA0) begin
      push(d, 64, 1'b0);
      crc_start = n_exp;
      push({48'h0, crc_ref(d, 64, 16)}, 16, 1'b1);
    end
    ones = 0;
    exp_stuff = 0;
    for (int i = 0; i < n_exp; i++) begin
      if (ones == STUFF) begin exp_stuff++; ones = 0; end
      ones = exp_raw[i] ? ones + 1 : 0;
    end
    if (ones == STUFF) exp_stuff++;
  endtask

  task automatic decode();
    logic prev, cur, b;
    int ones;
    prev = 1'b1;
    ones = 0;
    got_raw = '0;
    n_raw = 0; n_stuff = 0; stuff_pre = 0; bad_stuff = 0; n_se0 = 0; eop_j = 0;
    for (int i = 0; i < n_lines; i++) begin
      if (line_buf[i] == 2'b00) begin
        n_se0++;
      end else if (n_se0 > 0) begin
        if (line_buf[i] == 2'b10) eop_j++;
      end else begin
        cur = (line_buf[i] == 2'b10);
        b = (cur == prev);
        prev = cur;
        if (ones == STUFF) begin
          if (b) bad_stuff++;
          n_stuff++;
          if (n_raw <= crc_start) stuff_pre++;
          ones = 0;
        end else if (n_raw < 128) begin
          got_raw[n_raw] = b;
          n_raw++;
          ones = b ? ones + 1 : 0;
        end
      end
    end
  endtask

  task automatic send(input pkt_t t, input logic [6:0] a, input logic [3:0] e,
                      input logic [63:0] d, input int retrig);
    int cyc, dones;
    build_exp(t, a, e, d);
    start = 1'b1; pkt_type = t; addr = a; endp = e; data_in = d;
    @(negedge clock);
    start = 1'b0;
    check("latency_host_sending", 128'(host_sending), 128'(1));
    n_lines = 0; cyc = 0; dones = 0;
    while (host_sending && cyc < 400) begin
      line_buf[n_lines] = {DP_out, DM_out};
      n_lines++;
      cyc++;
      if (done) dones++;
      if (cyc == retrig) begin start = 1'b1; pkt_type = PKT_NAK; end
      else start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    check("sending_bounded", 128'(cyc < 400), 128'(1));
    check("done_after_eop", 128'(done), 128'(1));
    check("ready_after_eop", 128'(ready), 128'(1));
    if (done) dones++;
    repeat (3) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("done_single_pulse", 128'(dones), 128'(1));
    decode();
    check("raw_stream", got_raw, exp_raw);
    check("raw_length", 128'(n_raw), 128'(n_exp));
    check("stuff_count", 128'(n_stuff), 128'(exp_stuff));
    check("stuff_bits_zero", 128'(bad_stuff), 128'(0));
    check("eop_se0_cycles", 128'(n_se0), 128'(2));
    check("eop_j_cycles", 128'(eop_j), 128'(1));
    check("packet_length", 128'(n_lines), 128'(n_exp + exp_stuff + 3));
    check("sync_lines", 128'({line_buf[0], line_buf[1], line_buf[2], line_buf[3],
                              line_buf[4], line_buf[5], line_buf[6], line_buf[7]}),
          128'(16'h6665));
    check("pid_byte", 128'(got_raw[15:8]), 128'(tb_pid(t)));
  endtask

  logic [15:0] crc_field;

  initial begin
    reset = 1'b1; start = 1'b0; pkt_type = PKT_ACK;
    addr = '0; endp = '0; data_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_dp", 128'(DP_out), 128'(1));
    check("reset_dm", 128'(DM_out), 128'(0));
    check("reset_host_sending", 128'(host_sending), 128'(0));
    check("reset_ready", 128'(ready), 128'(1));
    check("reset_done", 128'(done), 128'(0));

    // ACK: 19 cycles on the wire, PID D2, no stuffing
    send(PKT_ACK, 7'h00, 4'h0, 64'h0, 0);
    check("ack_length", 128'(n_lines), 128'(19));
    check("ack_pid", 128'(got_raw[15:8]), 128'(8'hD2));
    check("ack_no_stuff", 128'(n_stuff), 128'(0));

    // OUT token addr 5 endp 0
    send(PKT_OUT, 7'h05, 4'h0, 64'h0, 0);
    check("out_pid", 128'(got_raw[15:8]), 128'(8'hE1));
    check("out_addr", 128'(got_raw[22:16]), 128'(7'h05));
    check("out_endp", 128'(got_raw[26:23]), 128'(4'h0));
    crc_field = '0;
    for (int i = 0; i < 5; i++) crc_field = {crc_field[14:0], got_raw[27+i]};
    check("out_crc5", 128'(crc_field), 128'(crc_ref({53'h0, 4'h0, 7'h05}, 11, 5)));

    // IN token, different fields
    send(PKT_IN, 7'h3A, 4'hB, 64'h0, 0);
    check("in_addr", 128'(got_raw[22:16]), 128'(7'h3A));
    check("in_endp", 128'(got_raw[26:23]), 128'(4'hB));

    // DATA0 all ones: run of 66 ones gives 11 stuffs before CRC
    send(PKT_DATA0, 7'h00, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("ones_stuff_pre_crc", 128'(stuff_pre), 128'(11));
    check("ones_payload", 128'(got_raw[79:16]), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    crc_field = '0;
    for (int i = 0; i < 16; i++) crc_field = {crc_field[14:0], got_raw[80+i]};
    check("ones_crc16", 128'(crc_field), 128'(crc_ref(64'hFFFF_FFFF_FFFF_FFFF, 64, 16)));

    // DATA0 all zeros: no payload stuffing
    send(PKT_DATA0, 7'h00, 4'h0, 64'h0, 0);
    check("zeros_stuff_pre_crc", 128'(stuff_pre), 128'(0));
    check("zeros_length", 128'(n_lines), 128'(99 + n_stuff));
    crc_field = '0;
    for (int i = 0; i < 16; i++) crc_field = {crc_field[14:0], got_raw[80+i]};
    check("zeros_crc16", 128'(crc_field), 128'(crc_ref(64'h0, 64, 16)));

    // Mixed payload
    send(PKT_DATA0, 7'h00, 4'h0, 64'h0123_4567_89AB_CDEF, 0);
    check("mixed_payload", 128'(got_raw[79:16]), 128'(64'h0123_4567_89AB_CDEF));

    // Illegal packet type is ignored
    start = 1'b1; pkt_type = pkt_t'(3'd7);
    @(negedge clock);
    start = 1'b0;
    check("illegal_host_sending", 128'(host_sending), 128'(0));
    check("illegal_ready", 128'(ready), 128'(1));
    check("illegal_line_j", 128'({DP_out, DM_out}), 128'(2'b10));
    @(negedge clock);

    // Second start 5 cycles into an ACK is ignored
    send(PKT_ACK, 7'h00, 4'h0, 64'h0, 5);
    check("retrig_length", 128'(n_lines), 128'(19));
    check("retrig_idle", 128'(host_sending), 128'(0));

    // Reset during DATA
    start = 1'b1; pkt_type = PKT_DATA0; data_in = 64'hA5A5_5A5A_0F0F_F0F0;
    @(negedge clock);
    start = 1'b0;
    repeat (29) @(negedge clock);
    check("mid_in_packet", 128'(host_sending), 128'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_line", 128'({DP_out, DM_out}), 128'(2'b10));
    check("mid_reset_host_sending", 128'(host_sending), 128'(0));
    check("mid_reset_ready", 128'(ready), 128'(1));
    check("mid_reset_done", 128'(done), 128'(0));
    begin
      int late_dones;
      late_dones = 0;
      repeat (3) begin
        @(negedge clock);
        if (done) late_dones++;
      end
      check("mid_reset_no_done", 128'(late_dones), 128'(0));
    end

    // NAK after reset
    send(PKT_NAK, 7'h00, 4'h0, 64'h0, 0);
    check("nak_pid", 128'(got_raw[15:8]), 128'(8'h5A));
    check("nak_length", 128'(n_lines), 128'(19));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
